// File: rtl/logic_op_arbiter_pkg.sv
// Shared opcode encodings and FSM state type for the logic-op arbiter.
package logic_op_arbiter_pkg;
  localparam logic [1:0] OP_NOT = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;
endpackage

// File: rtl/logic_op_arbiter_rr_priority_pick.sv
// Round-robin picker: first set request bit scanning upward from last+1, wrapping.
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);
  always_comb begin
    int idx;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_i) + k) % N;
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        idx_o      = IDX_W'(idx);
      end
    end
  end
endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin sharing of one NOT/AND/OR/XOR unit with a single registered response.
// Optional LOGIC_ARB_CNT_EN adds a saturating completed-response counter on Busy_Count.
module logic_op_arbiter #(
  parameter int NrOfBits = 8,
  parameter int NrOfReq  = 4
) (
  input  logic                         GlobalClock,
  input  logic                         Reset,
  input  logic [NrOfReq-1:0]           Req_Valid,
  output logic [NrOfReq-1:0]           Req_Ready,
  input  logic [2*NrOfReq-1:0]         Req_Op,
  input  logic [NrOfBits*NrOfReq-1:0]  Req_A,
  input  logic [NrOfBits*NrOfReq-1:0]  Req_B,
  output logic [NrOfReq-1:0]           Rsp_Valid,
  output logic [NrOfBits-1:0]          Rsp_Data,
  input  logic                         Rsp_Ready
`ifdef LOGIC_ARB_CNT_EN
  ,
  output logic [15:0]                  Busy_Count
`endif
);
  import logic_op_arbiter_pkg::*;

  localparam int IDX_W = (NrOfReq > 1) ? $clog2(NrOfReq) : 1;

  state_e                state_q, state_d;
  logic [NrOfReq-1:0]    rsp_valid_q, rsp_valid_d;
  logic [NrOfBits-1:0]   rsp_data_q, rsp_data_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;

  logic [NrOfReq-1:0]    pick_gnt;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic                  accept;
  logic [1:0]            sel_op;
  logic [NrOfBits-1:0]   sel_a, sel_b, op_res;

  rr_priority_pick #(.N(NrOfReq), .IDX_W(IDX_W)) u_pick (
    .req_i  (Req_Valid),
    .last_i (last_grant_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Reset is synchronous, so gate the handshake explicitly while it is held.
  assign accept    = (state_q == IDLE) && pick_any && !Reset;
  assign Req_Ready = accept ? pick_gnt : '0;

  always_comb begin
    sel_op = Req_Op[2*int'(pick_idx) +: 2];
    sel_a  = Req_A[NrOfBits*int'(pick_idx) +: NrOfBits];
    sel_b  = Req_B[NrOfBits*int'(pick_idx) +: NrOfBits];
    case (sel_op)
      OP_NOT:  op_res = ~sel_a;
      OP_AND:  op_res = sel_a & sel_b;
      OP_OR:   op_res = sel_a | sel_b;
      default: op_res = sel_a ^ sel_b;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        rsp_valid_d = '0;
        if (accept) begin
          rsp_data_d   = op_res;
          rsp_valid_d  = pick_gnt;
          last_grant_d = pick_idx;
          state_d      = RESP;
        end
      end
      default: begin
        if (Rsp_Ready) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge GlobalClock) begin
    if (Reset) begin
      state_q      <= IDLE;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      last_grant_q <= IDX_W'(NrOfReq - 1);
    end else begin
      state_q      <= state_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign Rsp_Valid = rsp_valid_q;
  assign Rsp_Data  = rsp_data_q;

`ifdef LOGIC_ARB_CNT_EN
  logic [15:0] busy_cnt_q, busy_cnt_d;

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (state_q == RESP && Rsp_Ready && busy_cnt_q != 16'hFFFF)
      busy_cnt_d = busy_cnt_q + 16'd1;
  end

  always_ff @(posedge GlobalClock) begin
    if (Reset) busy_cnt_q <= '0;
    else       busy_cnt_q <= busy_cnt_d;
  end

  assign Busy_Count = busy_cnt_q;
`endif
endmodule

// File: tb/tb_logic_op_arbiter.sv
// Scoreboard bench for logic_op_arbiter: grant order, op results, hold, wrap, reset.
module tb_logic_op_arbiter;
  localparam int NB = 8;
  localparam int NR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [NR-1:0]      req_valid, req_ready, rsp_valid;
  logic [2*NR-1:0]    req_op;
  logic [NB*NR-1:0]   req_a, req_b;
  logic [NB-1:0]      rsp_data;
  logic               rsp_ready;
`ifdef LOGIC_ARB_CNT_EN
  logic [15:0]        busy_count;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [NR-1:0] oh;
    logic [NB-1:0] data;
  } exp_t;
  exp_t sbq[$];

  logic_op_arbiter #(.NrOfBits(NB), .NrOfReq(NR)) dut (
    .GlobalClock (clk),
    .Reset       (rst),
    .Req_Valid   (req_valid),
    .Req_Ready   (req_ready),
    .Req_Op      (req_op),
    .Req_A       (req_a),
    .Req_B       (req_b),
    .Rsp_Valid   (rsp_valid),
    .Rsp_Data    (rsp_data),
    .Rsp_Ready   (rsp_ready)
`ifdef LOGIC_ARB_CNT_EN
    ,
    .Busy_Count  (busy_count)
`endif
  );

  function automatic logic [NB-1:0] f_op(input logic [1:0] op, input logic [NB-1:0] a, input logic [NB-1:0] b);
    case (op)
      2'b00:   return ~a;
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic exp_t f_exp(input int r);
    exp_t e;
    e.oh   = NR'(1) << r;
    e.data = f_op(req_op[2*r +: 2], req_a[NB*r +: NB], req_b[NB*r +: NB]);
    return e;
  endfunction

  task automatic set_req(input int r, input logic [1:0] op, input logic [NB-1:0] a, input logic [NB-1:0] b);
    req_op[2*r +: 2] = op;
    req_a[NB*r +: NB] = a;
    req_b[NB*r +: NB] = b;
  endtask

  // Leaves the bench 1ns after a posedge with reset released.
  task automatic do_reset;
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
    req_op = '0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (rsp_valid !== '0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_data !== '0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=00", rsp_data); end
    #1;
    total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
`ifdef LOGIC_ARB_CNT_EN
    total++; if (busy_count !== 16'd0) begin bad++; $display("FAIL reset_busy got=%0d exp=0", busy_count); end
`endif
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_not;
    exp_t e;
    set_req(0, 2'b00, 8'h5A, 8'h00);
    req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL not_ready got=%b exp=0001", req_ready); end
    if (req_ready !== '0) sbq.push_back(f_exp(0));
    @(posedge clk); #1;
    req_valid = '0;
    total++;
    if (sbq.size() == 0) begin bad++; $display("FAIL not_rsp no expected entry, got valid=%b", rsp_valid); end
    else begin
      e = sbq.pop_front();
      if (rsp_valid !== e.oh || rsp_data !== e.data) begin
        bad++; $display("FAIL not_rsp got=%b/%h exp=%b/%h", rsp_valid, rsp_data, e.oh, e.data);
      end
    end
    total++; if (rsp_data !== 8'hA5) begin bad++; $display("FAIL not_data got=%h exp=a5", rsp_data); end
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== '0) begin bad++; $display("FAIL not_resp_ready got=%b exp=0", req_ready); end
    @(posedge clk); #1;
    total++; if (rsp_valid !== '0) begin bad++; $display("FAIL not_done got=%b exp=0", rsp_valid); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_round_robin;
    int gseq [5] = '{0, 1, 2, 3, 0};
    int ng = 0;
    int npop = 0;
    exp_t e;
    logic [NR-1:0] exp_oh;
    do_reset();
    set_req(0, 2'b01, 8'hF0, 8'h3C);
    set_req(1, 2'b10, 8'h0F, 8'hA0);
    set_req(2, 2'b11, 8'hFF, 8'h5A);
    set_req(3, 2'b00, 8'h3C, 8'h00);
    req_valid = '1; rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req_ready !== '0) begin
        total++;
        exp_oh = (ng < 5) ? NR'(1) << gseq[ng] : '0;
        if (req_ready !== exp_oh) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", ng, req_ready, exp_oh); end
        if (ng < 5) sbq.push_back(f_exp(gseq[ng]));
        ng++;
      end
      @(posedge clk); #1;
      if (rsp_valid !== '0) begin
        total++;
        if (sbq.size() == 0) begin bad++; $display("FAIL rr_rsp unexpected valid=%b", rsp_valid); end
        else begin
          e = sbq.pop_front();
          if (rsp_valid !== e.oh || rsp_data !== e.data) begin
            bad++; $display("FAIL rr_rsp%0d got=%b/%h exp=%b/%h", npop, rsp_valid, rsp_data, e.oh, e.data);
          end
        end
        if (npop == 0) begin
          total++; if (rsp_data !== 8'h30) begin bad++; $display("FAIL rr_and got=%h exp=30", rsp_data); end
        end
        npop++;
      end
    end
    total++; if (ng != 5 || npop != 5) begin bad++; $display("FAIL rr_count grants=%0d rsps=%0d exp=5/5", ng, npop); end
    req_valid = '0; rsp_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_hold;
    exp_t e;
    do_reset();
    set_req(1, 2'b01, 8'hCC, 8'hAA);
    req_valid = 4'b0010;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL hold_grant got=%b exp=0010", req_ready); end
    sbq.push_back(f_exp(1));
    @(posedge clk); #1;
    req_valid = '1;
    e = sbq.pop_front();
    total++; if (rsp_data !== 8'h88) begin bad++; $display("FAIL hold_and got=%h exp=88", rsp_data); end
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (rsp_valid !== e.oh || rsp_data !== e.data || req_ready !== '0) begin
        bad++; $display("FAIL hold_c%0d got=%b/%h rdy=%b exp=%b/%h rdy=0", c, rsp_valid, rsp_data, req_ready, e.oh, e.data);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1; req_valid = '0;
    @(posedge clk); #1;
    total++; if (rsp_valid !== '0) begin bad++; $display("FAIL hold_release got=%b exp=0", rsp_valid); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_wrap;
    int gseq [2] = '{0, 3};
    int ng = 0;
    exp_t e;
    logic [NR-1:0] exp_oh;
    do_reset();
    set_req(3, 2'b11, 8'h0F, 8'hFF);
    set_req(0, 2'b10, 8'h81, 8'h18);
    req_valid = 4'b1000; rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_pre got=%b exp=1000", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b1001;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (req_ready !== '0) begin
        total++;
        exp_oh = (ng < 2) ? NR'(1) << gseq[ng] : '0;
        if (req_ready !== exp_oh) begin bad++; $display("FAIL wrap_grant%0d got=%b exp=%b", ng, req_ready, exp_oh); end
        if (ng < 2) sbq.push_back(f_exp(gseq[ng]));
        ng++;
      end
      @(posedge clk); #1;
      if (rsp_valid !== '0) begin
        total++;
        if (sbq.size() == 0) begin bad++; $display("FAIL wrap_rsp unexpected valid=%b", rsp_valid); end
        else begin
          e = sbq.pop_front();
          if (rsp_valid !== e.oh || rsp_data !== e.data) begin
            bad++; $display("FAIL wrap_rsp got=%b/%h exp=%b/%h", rsp_valid, rsp_data, e.oh, e.data);
          end
        end
      end
    end
    total++; if (ng != 2) begin bad++; $display("FAIL wrap_count grants=%0d exp=2", ng); end
    req_valid = '0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_in_resp;
    exp_t e;
    do_reset();
    set_req(2, 2'b10, 8'h12, 8'h40);
    req_valid = 4'b0100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rir_pre got=%b exp=0100", req_ready); end
    @(posedge clk); #1;
    req_valid = '0; rsp_ready = 1'b0;
    total++; if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL rir_resp got=%b exp=0100", rsp_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (rsp_valid !== '0 || rsp_data !== '0) begin bad++; $display("FAIL rir_cleared got=%b/%h exp=0/00", rsp_valid, rsp_data); end
    sbq.delete();
    set_req(3, 2'b01, 8'hFF, 8'h0F);
    req_valid = 4'b1100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rir_first got=%b exp=0100", req_ready); end
    sbq.push_back(f_exp(2));
    @(posedge clk); #1;
    req_valid = '0;
    e = sbq.pop_front();
    total++; if (rsp_valid !== e.oh || rsp_data !== e.data) begin bad++; $display("FAIL rir_rsp got=%b/%h exp=%b/%h", rsp_valid, rsp_data, e.oh, e.data); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

`ifdef LOGIC_ARB_CNT_EN
  task automatic test_counter;
    do_reset();
    set_req(0, 2'b01, 8'hFF, 8'h11);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    req_valid = '0;
    @(posedge clk); #1;
    total++; if (busy_count !== 16'd3) begin bad++; $display("FAIL cnt_three got=%0d exp=3", busy_count); end
    rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    test_reset();
    test_not();
    test_round_robin();
    test_hold();
    test_wrap();
    test_reset_in_resp();
`ifdef LOGIC_ARB_CNT_EN
    test_counter();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
